hamming_encoder_tx: RTL

//  Transmit side of the 11-bit SECDED link: encodes 6-bit payload into (11,6) Hamming+overall-parity codeword.

---
 rtl/hamming_encoder_tx_if.sv | 37 +++
 rtl/hamming_encoder_tx.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/hamming_encoder_tx_if.sv
// Parallel/serial link bundle between the (11,6) SECDED encoder and its user.
// The master drives payload and handshake; the slave is the encoder.
interface hamming_encoder_tx_if;
    logic [5:0]  data_in;
    logic [10:0] err_mask;
    logic        in_valid;
    logic        in_ready;
    logic [10:0] code_out;
    logic        code_stb;
    logic        ser_out;
    logic        ser_frame;
    logic        busy;

    modport master (
        output data_in,
        output err_mask,
        output in_valid,
        input  in_ready,
        input  code_out,
        input  code_stb,
        input  ser_out,
        input  ser_frame,
        input  busy
    );

    modport slave (
        input  data_in,
        input  err_mask,
        input  in_valid,
        output in_ready,
        output code_out,
        output code_stb,
        output ser_out,
        output ser_frame,
        output busy
    );
endinterface

// File: rtl/hamming_encoder_tx.sv
// Transmit side of the 11-bit SECDED link: encodes a 6-bit payload into an
// (11,6) Hamming + overall-parity codeword, presents it in parallel and shifts it out LSB (position 1) first.
module hamming_encoder_tx #(
    parameter int BIT_PERIOD = 1,
    parameter int GAP_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    hamming_encoder_tx_if.slave  link
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    localparam int BIT_CNT_W = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD + 1) : 1;
    localparam int GAP_CNT_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(BIT_PERIOD - 1);
    localparam logic [GAP_CNT_W-1:0] GAP_LAST = GAP_CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [3:0]           IDX_LAST = 4'd10;
    localparam bit                   HAS_GAP  = (GAP_CYCLES > 0);

    // Parity bit k covers every codeword position (1..10) whose index has bit k set.
    function automatic logic [9:0] cover_mask(input int k);
        logic [9:0] m;
        m = '0;
        for (int p = 1; p <= 10; p++) begin
            m[p-1] = ((p >> k) & 1) == 1;
        end
        return m;
    endfunction

    // ------------------------------------------------------------------
    // Combinational encoder
    // ------------------------------------------------------------------
    logic [10:0] placed;
    logic [3:0]  parity;
    logic [10:0] with_parity;
    logic [10:0] encoded;
    logic [10:0] code_next_word;

    assign placed = {1'b0, link.data_in[5], link.data_in[4], 1'b0,
                     link.data_in[3], link.data_in[2], link.data_in[1], 1'b0,
                     link.data_in[0], 2'b00};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_parity
            localparam logic [9:0] COVER = cover_mask(gi);
            assign parity[gi] = ^(placed[9:0] & COVER);
        end
    endgenerate

    assign with_parity    = placed | {3'b000, parity[3], 3'b000, parity[2], 1'b0, parity[1], parity[0]};
    assign encoded        = {^with_parity[9:0], with_parity[9:0]};
    assign code_next_word = encoded ^ link.err_mask;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]           state_reg,     state_next;
    logic [10:0]          code_out_reg,  code_out_next;
    logic                 code_stb_reg,  code_stb_next;
    logic                 ser_out_reg,   ser_out_next;
    logic                 ser_frame_reg, ser_frame_next;
    logic                 in_ready_reg,  in_ready_next;
    logic [3:0]           idx_reg,       idx_next;
    logic [BIT_CNT_W-1:0] bit_cnt_reg,   bit_cnt_next;
    logic [GAP_CNT_W-1:0] gap_cnt_reg,   gap_cnt_next;

    logic handshake;
    assign handshake = link.in_valid & in_ready_reg;

    always_comb begin
        state_next     = state_reg;
        code_out_next  = code_out_reg;
        code_stb_next  = 1'b0;
        ser_out_next   = ser_out_reg;
        ser_frame_next = ser_frame_reg;
        in_ready_next  = in_ready_reg;
        idx_next       = idx_reg;
        bit_cnt_next   = bit_cnt_reg;
        gap_cnt_next   = gap_cnt_reg;

        case (state_reg)
            ST_IDLE: begin
                // in_ready rises one clock after reset release, then stays up while idle.
                in_ready_next = 1'b1;
                if (handshake) begin
                    code_out_next  = code_next_word;
                    code_stb_next  = 1'b1;
                    state_next     = ST_SHIFT;
                    idx_next       = 4'd0;
                    bit_cnt_next   = '0;
                    ser_frame_next = 1'b1;
                    ser_out_next   = code_next_word[0];
                    in_ready_next  = 1'b0;
                end
            end

            ST_SHIFT: begin
                if (bit_cnt_reg == BIT_LAST) begin
                    bit_cnt_next = '0;
                    if (idx_reg == IDX_LAST) begin
                        ser_frame_next = 1'b0;
                        ser_out_next   = 1'b0;
                        idx_next       = 4'd0;
                        gap_cnt_next   = '0;
                        if (HAS_GAP) begin
                            state_next = ST_GAP;
                        end else begin
                            state_next    = ST_IDLE;
                            in_ready_next = 1'b1;
                        end
                    end else begin
                        idx_next     = idx_reg + 4'd1;
                        ser_out_next = code_out_reg[idx_reg + 4'd1];
                    end
                end else begin
                    bit_cnt_next = bit_cnt_reg + 1'b1;
                end
            end

            ST_GAP: begin
                if (gap_cnt_reg == GAP_LAST) begin
                    gap_cnt_next  = '0;
                    state_next    = ST_IDLE;
                    in_ready_next = 1'b1;
                end else begin
                    gap_cnt_next = gap_cnt_reg + 1'b1;
                end
            end

            default: begin
                state_next     = ST_IDLE;
                ser_frame_next = 1'b0;
                ser_out_next   = 1'b0;
                in_ready_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            code_out_reg  <= '0;
            code_stb_reg  <= 1'b0;
            ser_out_reg   <= 1'b0;
            ser_frame_reg <= 1'b0;
            in_ready_reg  <= 1'b0;
            idx_reg       <= 4'd0;
            bit_cnt_reg   <= '0;
            gap_cnt_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            code_out_reg  <= code_out_next;
            code_stb_reg  <= code_stb_next;
            ser_out_reg   <= ser_out_next;
            ser_frame_reg <= ser_frame_next;
            in_ready_reg  <= in_ready_next;
            idx_reg       <= idx_next;
            bit_cnt_reg   <= bit_cnt_next;
            gap_cnt_reg   <= gap_cnt_next;
        end
    end

    assign link.in_ready  = in_ready_reg;
    assign link.code_out  = code_out_reg;
    assign link.code_stb  = code_stb_reg;
    assign link.ser_out   = ser_out_reg;
    assign link.ser_frame = ser_frame_reg;
    assign link.busy      = (state_reg != ST_IDLE);

endmodule
